// File: rtl/l1_memory_port_arbiter_pkg.sv
// Shared types for the L1 memory port arbiter: FSM states, master IDs and the
// request beat payload carried from either cache to the memory port.
package l1_mem_arb_pkg;

  localparam int L1_MEM_ARB_MAX_OUTSTANDING = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GNT_INST   = 2'd1,
    GNT_DCACHE = 2'd2
  } arb_state_e;

  typedef enum logic {
    INST   = 1'b0,
    DCACHE = 1'b1
  } master_id_e;

  typedef struct packed {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_beat_t;

endpackage

// File: rtl/l1_memory_port_arbiter_if.sv
// Bundles for one L1 cache port and for the shared memory port. Signal prefixes
// (i/o) are named from the arbiter's point of view.
interface l1_cache_port_if;
  logic        iREQ;
  logic        oLOCK;
  logic [1:0]  iORDER;
  logic [3:0]  iMASK;
  logic        iRW;
  logic [31:0] iADDR;
  logic [31:0] iDATA;
  logic        oVALID;
  logic [63:0] oDATA;

  modport master (output iREQ, iORDER, iMASK, iRW, iADDR, iDATA,
                  input  oLOCK, oVALID, oDATA);
  modport slave  (input  iREQ, iORDER, iMASK, iRW, iADDR, iDATA,
                  output oLOCK, oVALID, oDATA);
endinterface

interface l1_mem_port_if;
  logic        oREQ;
  logic [1:0]  oORDER;
  logic [3:0]  oMASK;
  logic        oRW;
  logic [31:0] oADDR;
  logic [31:0] oDATA;
  logic        iLOCK;
  logic        iVALID;
  logic [63:0] iDATA;

  modport master (output oREQ, oORDER, oMASK, oRW, oADDR, oDATA,
                  input  iLOCK, iVALID, iDATA);
  modport slave  (input  oREQ, oORDER, oMASK, oRW, oADDR, oDATA,
                  output iLOCK, iVALID, iDATA);
endinterface

// File: rtl/l1_memory_port_arbiter_outstanding_cnt.sv
// Counts accepted-but-unanswered beats and flags responses that arrive with
// nothing outstanding (sticky until reset or clear).
module l1_mem_arb_outstanding_cnt #(
  parameter int P_MAX_OUTSTANDING = 8,
  parameter int P_CNT_W           = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               accept,
  input  logic               valid,
  output logic [P_CNT_W-1:0] cnt,
  output logic               full,
  output logic               zero_next,
  output logic               err
);

  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               dec;

  // A response only retires a beat when one is actually outstanding.
  always_comb begin
    dec   = valid & (cnt_q != '0);
    cnt_d = cnt_q + P_CNT_W'(accept) - P_CNT_W'(dec);
    err_d = err_q | (valid & (cnt_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt       = cnt_q;
  assign full      = (cnt_q == P_CNT_W'(P_MAX_OUTSTANDING));
  assign zero_next = (cnt_d == '0);
  assign err       = err_q;

endmodule

// File: rtl/l1_memory_port_arbiter.sv
// Round-robin owner of the single memory port shared by the L1 instruction and
// data caches; responses are steered back to whichever cache owns the port.
module l1_memory_port_arbiter
  import l1_mem_arb_pkg::*;
#(
  parameter int P_MAX_OUTSTANDING = L1_MEM_ARB_MAX_OUTSTANDING,
  parameter int P_CNT_W           = 4
) (
  input  logic           iCLOCK,
  input  logic           iRESET,
  input  logic           iRESET_SYNC,
  l1_cache_port_if.slave inst_if,
  l1_cache_port_if.slave dcache_if,
  l1_mem_port_if.master  mem_if,
  output logic           oPROTO_ERR
);

  arb_state_e         state_q, state_d;
  master_id_e         last_q, last_d;
  mem_beat_t          owner_beat;
  logic               owner_req, owner_lock, accept, rsp_live;
  logic               cnt_full, cnt_zero_next;
  logic [P_CNT_W-1:0] cnt;

  l1_mem_arb_outstanding_cnt #(
    .P_MAX_OUTSTANDING(P_MAX_OUTSTANDING),
    .P_CNT_W          (P_CNT_W)
  ) u_cnt (
    .clk      (iCLOCK),
    .rst      (iRESET),
    .clear    (iRESET_SYNC),
    .accept   (accept),
    .valid    (mem_if.iVALID),
    .cnt      (cnt),
    .full     (cnt_full),
    .zero_next(cnt_zero_next),
    .err      (oPROTO_ERR)
  );

  always_comb begin
    owner_req  = 1'b0;
    owner_beat = '0;
    case (state_q)
      GNT_INST: begin
        owner_req        = inst_if.iREQ;
        owner_beat.order = inst_if.iORDER;
        owner_beat.mask  = inst_if.iMASK;
        owner_beat.rw    = inst_if.iRW;
        owner_beat.addr  = inst_if.iADDR;
        owner_beat.data  = inst_if.iDATA;
      end
      GNT_DCACHE: begin
        owner_req        = dcache_if.iREQ;
        owner_beat.order = dcache_if.iORDER;
        owner_beat.mask  = dcache_if.iMASK;
        owner_beat.rw    = dcache_if.iRW;
        owner_beat.addr  = dcache_if.iADDR;
        owner_beat.data  = dcache_if.iDATA;
      end
      default: ;
    endcase
    // The cap looks at the registered count, so a slot freed this cycle opens next cycle.
    owner_lock = mem_if.iLOCK | cnt_full;
    accept     = owner_req & ~owner_lock;
    rsp_live   = mem_if.iVALID & (cnt != '0);
  end

  // Ownership is released only once the owner is quiet and nothing is left in flight.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (inst_if.iREQ && dcache_if.iREQ) begin
          if (last_q == INST) begin
            state_d = GNT_DCACHE;
            last_d  = DCACHE;
          end else begin
            state_d = GNT_INST;
            last_d  = INST;
          end
        end else if (inst_if.iREQ) begin
          state_d = GNT_INST;
          last_d  = INST;
        end else if (dcache_if.iREQ) begin
          state_d = GNT_DCACHE;
          last_d  = DCACHE;
        end
      end
      GNT_INST: begin
        if (!inst_if.iREQ && cnt_zero_next) begin
          if (dcache_if.iREQ) begin
            state_d = GNT_DCACHE;
            last_d  = DCACHE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT_DCACHE: begin
        if (!dcache_if.iREQ && cnt_zero_next) begin
          if (inst_if.iREQ) begin
            state_d = GNT_INST;
            last_d  = INST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE;
      last_q  <= INST;
    end else if (iRESET_SYNC) begin
      state_q <= IDLE;
      last_q  <= INST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign inst_if.oLOCK    = (state_q == GNT_INST)   ? owner_lock : 1'b1;
  assign dcache_if.oLOCK  = (state_q == GNT_DCACHE) ? owner_lock : 1'b1;
  assign inst_if.oVALID   = rsp_live & (state_q == GNT_INST);
  assign dcache_if.oVALID = rsp_live & (state_q == GNT_DCACHE);
  assign inst_if.oDATA    = mem_if.iDATA;
  assign dcache_if.oDATA  = mem_if.iDATA;

  assign mem_if.oREQ   = owner_req;
  assign mem_if.oORDER = owner_beat.order;
  assign mem_if.oMASK  = owner_beat.mask;
  assign mem_if.oRW    = owner_beat.rw;
  assign mem_if.oADDR  = owner_beat.addr;
  assign mem_if.oDATA  = owner_beat.data;

endmodule

// File: tb/tb_l1_memory_port_arbiter.sv
// Self-checking bench for l1_memory_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_l1_memory_port_arbiter;

  localparam int MAX = 8;

  int   checks   = 0;
  int   failures = 0;
  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic rstSync  = 1'b0;
  logic protoErr;
  bit   checkEn  = 1'b0;

  logic        reqV  [2];
  logic [1:0]  ordV  [2];
  logic [3:0]  maskV [2];
  logic        rwV   [2];
  logic [31:0] addrV [2];
  logic [31:0] dataV [2];
  logic        memLock  = 1'b0;
  logic        memValid = 1'b0;
  logic [63:0] memData  = '0;

  int mOwner = -1;
  int mCnt   = 0;
  int mLast  = 0;
  bit mErr   = 1'b0;
  bit accepted [2];

  l1_cache_port_if instIf ();
  l1_cache_port_if dcIf ();
  l1_mem_port_if   memIf ();

  assign instIf.iREQ   = reqV[0];
  assign instIf.iORDER = ordV[0];
  assign instIf.iMASK  = maskV[0];
  assign instIf.iRW    = rwV[0];
  assign instIf.iADDR  = addrV[0];
  assign instIf.iDATA  = dataV[0];
  assign dcIf.iREQ     = reqV[1];
  assign dcIf.iORDER   = ordV[1];
  assign dcIf.iMASK    = maskV[1];
  assign dcIf.iRW      = rwV[1];
  assign dcIf.iADDR    = addrV[1];
  assign dcIf.iDATA    = dataV[1];
  assign memIf.iLOCK   = memLock;
  assign memIf.iVALID  = memValid;
  assign memIf.iDATA   = memData;

  l1_memory_port_arbiter #(
    .P_MAX_OUTSTANDING(MAX),
    .P_CNT_W          (4)
  ) dut (
    .iCLOCK     (clk),
    .iRESET     (rst),
    .iRESET_SYNC(rstSync),
    .inst_if    (instIf),
    .dcache_if  (dcIf),
    .mem_if     (memIf),
    .oPROTO_ERR (protoErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Owner sees memory back-pressure or the outstanding cap; everyone else is held off.
  function automatic logic modelLock(input int m);
    return (mOwner == m) ? (memLock || mCnt == MAX) : 1'b1;
  endfunction

  task automatic compareAll();
    logic        eReq, eRw;
    logic [1:0]  eOrd;
    logic [3:0]  eMask;
    logic [31:0] eAddr, eData;
    eReq = 1'b0; eRw = 1'b0; eOrd = '0; eMask = '0; eAddr = '0; eData = '0;
    if (mOwner >= 0) begin
      eReq = reqV[mOwner]; eRw = rwV[mOwner]; eOrd = ordV[mOwner];
      eMask = maskV[mOwner]; eAddr = addrV[mOwner]; eData = dataV[mOwner];
    end
    checkOutput("INST_LOCK",    64'(instIf.oLOCK),  64'(modelLock(0)));
    checkOutput("DCACHE_LOCK",  64'(dcIf.oLOCK),    64'(modelLock(1)));
    checkOutput("INST_VALID",   64'(instIf.oVALID), 64'(memValid && mOwner == 0 && mCnt != 0));
    checkOutput("DCACHE_VALID", 64'(dcIf.oVALID),   64'(memValid && mOwner == 1 && mCnt != 0));
    checkOutput("INST_DATA",    instIf.oDATA,       memData);
    checkOutput("DCACHE_DATA",  dcIf.oDATA,         memData);
    checkOutput("MEM_REQ",      64'(memIf.oREQ),    64'(eReq));
    checkOutput("MEM_PAYLOAD",  {25'd0, memIf.oORDER, memIf.oMASK, memIf.oRW, memIf.oADDR},
                                {25'd0, eOrd, eMask, eRw, eAddr});
    checkOutput("MEM_WDATA",    64'(memIf.oDATA),   64'(eData));
    checkOutput("PROTO_ERR",    64'(protoErr),      64'(mErr));
  endtask

  // Advance the model to the state the next rising edge will produce from the current inputs.
  task automatic modelStep();
    bit acc, dec;
    int nxt;
    accepted[0] = 1'b0;
    accepted[1] = 1'b0;
    if (rst || rstSync) begin
      mOwner = -1; mCnt = 0; mLast = 0; mErr = 1'b0;
      return;
    end
    acc = (mOwner >= 0) && reqV[mOwner] && !modelLock(mOwner);
    dec = memValid && (mCnt > 0);
    if (memValid && mCnt == 0) mErr = 1'b1;
    nxt = mCnt + int'(acc) - int'(dec);
    if (acc) accepted[mOwner] = 1'b1;
    if (mOwner < 0) begin
      if (reqV[0] && reqV[1]) mOwner = 1 - mLast;
      else if (reqV[0])       mOwner = 0;
      else if (reqV[1])       mOwner = 1;
      if (mOwner >= 0) mLast = mOwner;
    end else if (!reqV[mOwner] && nxt == 0) begin
      if (reqV[1 - mOwner]) begin
        mOwner = 1 - mOwner;
        mLast  = mOwner;
      end else begin
        mOwner = -1;
      end
    end
    mCnt = nxt;
  endtask

  // Inputs change only on falling edges, so mid-low-phase is a stable point to compare and step.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      mOwner = -1; mCnt = 0; mLast = 0; mErr = 1'b0;
    end
    if (checkEn) compareAll();
    modelStep();
  end

  task automatic setBeat(input int m, input logic rw, input logic [31:0] addr, input logic [31:0] data);
    ordV[m] = 2'(m + 1); maskV[m] = 4'hF; rwV[m] = rw; addrV[m] = addr; dataV[m] = data;
  endtask

  task automatic randomBeat(input int m);
    ordV[m] = 2'($urandom); maskV[m] = 4'($urandom); rwV[m] = 1'($urandom);
    addrV[m] = $urandom; dataV[m] = $urandom;
  endtask

  task automatic applyStimulusReset();
    @(negedge clk);
    rst = 1'b1; rstSync = 1'b0;
    reqV[0] = 1'b0; reqV[1] = 1'b0; memLock = 1'b0; memValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drainAll();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      reqV[0] = 1'b0; reqV[1] = 1'b0; memLock = 1'b0;
      memValid = (mCnt > 0);
      memData = {$urandom, $urandom};
      done = (mCnt == 0 && mOwner < 0);
    end
    checkOutput("DRAIN_DONE", 64'(done), 64'd1);
  endtask

  int reqPct [2];
  int lockPct, validPct;
  int k, lockLeft, instV, dcV, dutAcc;
  int phaseTab [5][4] = '{'{90, 90, 10, 50}, '{30, 70, 30, 20}, '{80, 10, 0, 90},
                          '{50, 50, 50, 5}, '{100, 100, 20, 40}};

  initial begin
    reqV[0] = 1'b0; reqV[1] = 1'b0;
    setBeat(0, 1'b1, 32'h0, 32'h0);
    setBeat(1, 1'b1, 32'h0, 32'h0);
    applyStimulusReset();
    checkEn = 1'b1;

    // DCACHE write alone
    @(negedge clk);
    setBeat(1, 1'b0, 32'h1000_0040, 32'hCAFE_0001); reqV[1] = 1'b1;
    #1;
    checkOutput("RST_INST_LOCK", 64'(instIf.oLOCK), 64'd1);
    checkOutput("RST_DC_LOCK",   64'(dcIf.oLOCK),   64'd1);
    checkOutput("RST_MEM_REQ",   64'(memIf.oREQ),   64'd0);
    checkOutput("RST_ERR",       64'(protoErr),     64'd0);
    @(negedge clk);
    #1;
    checkOutput("WR_DC_LOCK_C1", 64'(dcIf.oLOCK),   64'd0);
    checkOutput("WR_ADDR_C1",    64'(memIf.oADDR),  64'h1000_0040);
    @(negedge clk); reqV[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    memValid = 1'b1; memData = 64'hDEAD_BEEF_0000_0001;
    #1;
    checkOutput("WR_DC_VALID_C4",   64'(dcIf.oVALID),   64'd1);
    checkOutput("WR_INST_VALID_C4", 64'(instIf.oVALID), 64'd0);
    checkOutput("WR_DC_DATA_C4",    dcIf.oDATA,         64'hDEAD_BEEF_0000_0001);
    @(negedge clk); memValid = 1'b0;
    #1;
    checkOutput("WR_IDLE_DC_LOCK", 64'(dcIf.oLOCK), 64'd1);
    checkOutput("WR_IDLE_MEM_REQ", 64'(memIf.oREQ), 64'd0);

    // Tie after reset: DCACHE first, then direct switch to INST
    applyStimulusReset();
    @(negedge clk);
    setBeat(0, 1'b1, 32'h2000_0000, 32'h0); reqV[0] = 1'b1;
    setBeat(1, 1'b0, 32'h3000_0000, 32'h55); reqV[1] = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("TIE_DC_LOCK_C1",   64'(dcIf.oLOCK),   64'd0);
    checkOutput("TIE_INST_LOCK_C1", 64'(instIf.oLOCK), 64'd1);
    checkOutput("TIE_ADDR_C1",      64'(memIf.oADDR),  64'h3000_0000);
    @(negedge clk);
    @(negedge clk); reqV[1] = 1'b0; memValid = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("TIE_INST_LOCK_C4", 64'(instIf.oLOCK), 64'd1);
    checkOutput("TIE_DC_VALID_C4",  64'(dcIf.oVALID),  64'd1);
    @(negedge clk); memValid = 1'b0;
    #1;
    checkOutput("TIE_INST_LOCK_C5", 64'(instIf.oLOCK), 64'd0);
    checkOutput("TIE_ADDR_C5",      64'(memIf.oADDR),  64'h2000_0000);
    @(negedge clk); reqV[0] = 1'b0;
    @(negedge clk); memValid = 1'b1;
    #1;
    checkOutput("TIE_INST_VALID_C7", 64'(instIf.oVALID), 64'd1);
    checkOutput("TIE_DC_VALID_C7",   64'(dcIf.oVALID),   64'd0);
    @(negedge clk); memValid = 1'b0;
    #1;
    checkOutput("TIE_IDLE_INST_LOCK", 64'(instIf.oLOCK), 64'd1);

    // Outstanding cap with responses held back
    applyStimulusReset();
    @(negedge clk);
    setBeat(1, 1'b1, 32'h4000_0000, 32'h0); reqV[1] = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    checkOutput("CAP_DC_LOCK_C8", 64'(dcIf.oLOCK), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("CAP_DC_LOCK_C9", 64'(dcIf.oLOCK), 64'd1);
    @(negedge clk); memValid = 1'b1;
    #1;
    checkOutput("CAP_DC_LOCK_C10", 64'(dcIf.oLOCK), 64'd1);
    @(negedge clk); memValid = 1'b0;
    #1;
    checkOutput("CAP_DC_LOCK_C11", 64'(dcIf.oLOCK), 64'd0);
    drainAll();

    // Stray response in IDLE
    @(negedge clk); memValid = 1'b1;
    #1;
    checkOutput("STRAY_INST_VALID", 64'(instIf.oVALID), 64'd0);
    checkOutput("STRAY_DC_VALID",   64'(dcIf.oVALID),   64'd0);
    @(negedge clk); memValid = 1'b0;
    #1;
    checkOutput("STRAY_ERR_SET", 64'(protoErr), 64'd1);
    repeat (3) @(negedge clk);
    @(negedge clk); rstSync = 1'b1;
    #1;
    checkOutput("STRAY_ERR_HELD", 64'(protoErr), 64'd1);
    @(negedge clk); rstSync = 1'b0;
    #1;
    checkOutput("STRAY_ERR_CLR", 64'(protoErr), 64'd0);

    // INST 8-beat fill with memory back-pressure on the third beat
    k = 0; lockLeft = 2; instV = 0; dcV = 0; dutAcc = 0;
    @(negedge clk);
    setBeat(0, 1'b1, 32'h8000_0100, 32'h0); reqV[0] = 1'b1;
    for (int i = 0; i < 120 && !(k == 8 && mCnt == 0); i++) begin
      @(negedge clk);
      if (accepted[0]) begin
        k++;
        if (k < 8) addrV[0] = 32'h8000_0100 + 32'(4 * k);
        else reqV[0] = 1'b0;
      end
      memLock = 1'b0;
      if (k == 2 && lockLeft > 0) begin
        memLock = 1'b1;
        lockLeft--;
      end
      memValid = (mCnt > 0) && ($urandom_range(0, 1) == 1);
      memData = {$urandom, $urandom};
      #1;
      if (instIf.oVALID) instV++;
      if (dcIf.oVALID) dcV++;
      if (reqV[0] && !instIf.oLOCK) dutAcc++;
      if (memLock) checkOutput("FILL_ADDR_LOCKED", 64'(memIf.oADDR), 64'h8000_0108);
    end
    checkOutput("FILL_ACCEPTS",    64'(dutAcc), 64'd8);
    checkOutput("FILL_INST_VALID", 64'(instV),  64'd8);
    checkOutput("FILL_DC_VALID",   64'(dcV),    64'd0);
    drainAll();

    // Async reset mid-fill at five outstanding beats
    @(negedge clk);
    setBeat(0, 1'b1, 32'h9000_0000, 32'h0); reqV[0] = 1'b1;
    for (int i = 0; i < 20 && mCnt != 5; i++) @(negedge clk);
    checkOutput("MIDRST_REACHED5", 64'(mCnt), 64'd5);
    rst = 1'b1;
    #1;
    checkOutput("MIDRST_INST_LOCK", 64'(instIf.oLOCK), 64'd1);
    checkOutput("MIDRST_DC_LOCK",   64'(dcIf.oLOCK),   64'd1);
    checkOutput("MIDRST_MEM_REQ",   64'(memIf.oREQ),   64'd0);
    checkOutput("MIDRST_MEM_ADDR",  64'(memIf.oADDR),  64'd0);
    @(negedge clk); rst = 1'b0; reqV[0] = 1'b0; memValid = 1'b1;
    #1;
    checkOutput("MIDRST_LATE_VALID", 64'(instIf.oVALID), 64'd0);
    @(negedge clk); memValid = 1'b0;
    setBeat(1, 1'b1, 32'hA000_0000, 32'h0); reqV[1] = 1'b1;
    #1;
    checkOutput("MIDRST_LATE_ERR", 64'(protoErr), 64'd1);
    @(negedge clk);
    #1;
    checkOutput("MIDRST_DC_GRANT", 64'(dcIf.oLOCK), 64'd0);
    drainAll();
    @(negedge clk); rstSync = 1'b1;
    @(negedge clk); rstSync = 1'b0;

    // Randomized traffic against the model
    for (int ph = 0; ph < 5; ph++) begin
      reqPct[0] = phaseTab[ph][0]; reqPct[1] = phaseTab[ph][1];
      lockPct = phaseTab[ph][2]; validPct = phaseTab[ph][3];
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
          if (!(reqV[m] && !accepted[m])) begin
            if ($urandom_range(0, 99) < reqPct[m]) begin
              reqV[m] = 1'b1;
              randomBeat(m);
            end else begin
              reqV[m] = 1'b0;
            end
          end
        end
        memLock  = ($urandom_range(0, 99) < lockPct);
        memValid = (mCnt > 0) && ($urandom_range(0, 99) < validPct);
        memData  = {$urandom, $urandom};
      end
    end
    drainAll();

    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
